if_axi_fetch: RTL and testbench

//  Instruction-fetch AXI4 read master feeding the IF-stage PC register. Takes the next fetch

---
 rtl/if_axi_fetch_pkg.sv | 22 ++
 rtl/if_axi_fetch.sv | 125 ++++++++++++
 tb/tb_if_axi_fetch.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_axi_fetch_pkg.sv
// Shared types and AXI constants for the instruction-fetch AXI read master.
package if_axi_fetch_pkg;

  localparam int unsigned IF_ADDR_W = 64;
  localparam int unsigned IF_DATA_W = 64;
  localparam int unsigned IF_INST_W = 32;

  // Fetch FSM encodings.
  typedef enum logic [1:0] {
    IFF_IDLE = 2'd0,
    IFF_ADDR = 2'd1,
    IFF_DATA = 2'd2
  } iff_state_e;

  // Single-beat, 8-byte, INCR instruction reads.
  localparam logic [7:0] AXI_LEN_1BEAT  = 8'd0;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_PROT_INST  = 3'b100;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/if_axi_fetch.sv
// Instruction-fetch AXI4 read master: one single-beat read per fetch, 32-bit lane select.
// Optional R-response error flag enabled by defining IF_FETCH_ERR_CHK_EN.
module if_axi_fetch
  import if_axi_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = IF_ADDR_W,
  parameter int unsigned DATA_W = IF_DATA_W,
  parameter int unsigned INST_W = IF_INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_addr,
  output logic              ar_valid,
  input  logic              ar_ready,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [7:0]        ar_len,
  output logic [2:0]        ar_size,
  output logic [1:0]        ar_burst,
  output logic [2:0]        ar_prot,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [DATA_W-1:0] r_data,
  input  logic [1:0]        r_resp,
  input  logic              r_last
`ifdef IF_FETCH_ERR_CHK_EN
  ,
  output logic              fetch_err
`endif
);

  iff_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;
  logic              inst_valid_q, inst_valid_d;
`ifdef IF_FETCH_ERR_CHK_EN
  logic              fetch_err_q, fetch_err_d;
`endif

  // r_last is always 1 for single-beat reads; r_resp only matters with error checking.
  logic unused_ok;
  assign unused_ok = ^{r_last, r_resp};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IFF_IDLE;
      addr_q       <= '0;
      inst_q       <= '0;
      inst_addr_q  <= '0;
      inst_valid_q <= 1'b0;
`ifdef IF_FETCH_ERR_CHK_EN
      fetch_err_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      inst_q       <= inst_d;
      inst_addr_q  <= inst_addr_d;
      inst_valid_q <= inst_valid_d;
`ifdef IF_FETCH_ERR_CHK_EN
      fetch_err_q  <= fetch_err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    inst_d       = inst_q;
    inst_addr_d  = inst_addr_q;
    inst_valid_d = 1'b0;
    ar_valid     = 1'b0;
    r_ready      = 1'b0;
`ifdef IF_FETCH_ERR_CHK_EN
    fetch_err_d  = fetch_err_q;
`endif
    case (state_q)
      IFF_IDLE: begin
        if (fetch_en) begin
          addr_d  = fetch_addr;
          state_d = IFF_ADDR;
        end
      end
      IFF_ADDR: begin
        ar_valid = 1'b1;
        if (ar_ready) begin
          state_d = IFF_DATA;
        end
      end
      IFF_DATA: begin
        r_ready = 1'b1;
        if (r_valid) begin
          // addr[2] picks the upper or lower instruction within the 64-bit beat.
          inst_d       = addr_q[2] ? r_data[2*INST_W-1:INST_W] : r_data[INST_W-1:0];
          inst_addr_d  = addr_q;
          inst_valid_d = 1'b1;
          state_d      = IFF_IDLE;
`ifdef IF_FETCH_ERR_CHK_EN
          fetch_err_d  = (r_resp != AXI_RESP_OKAY);
`endif
        end
      end
      default: begin
        state_d = IFF_IDLE;
      end
    endcase
  end

  assign ar_addr    = {addr_q[ADDR_W-1:3], 3'b000};
  assign ar_len     = AXI_LEN_1BEAT;
  assign ar_size    = AXI_SIZE_8B;
  assign ar_burst   = AXI_BURST_INCR;
  assign ar_prot    = AXI_PROT_INST;
  assign inst       = inst_q;
  assign inst_addr  = inst_addr_q;
  assign inst_valid = inst_valid_q;
`ifdef IF_FETCH_ERR_CHK_EN
  assign fetch_err  = fetch_err_q;
`endif

endmodule

// File: tb/tb_if_axi_fetch.sv
// Directed self-checking bench for if_axi_fetch with a scoreboard of expected fetch results.
module tb_if_axi_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic [63:0] fetch_addr = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_addr;
  logic        ar_valid;
  logic        ar_ready = 1'b0;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic [2:0]  ar_prot;
  logic        r_valid = 1'b0;
  logic        r_ready;
  logic [63:0] r_data = '0;
  logic [1:0]  r_resp = 2'b00;
  logic        r_last = 1'b1;
`ifdef IF_FETCH_ERR_CHK_EN
  logic        fetch_err;
`endif

  typedef struct {
    logic [31:0] inst;
    logic [63:0] addr;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pulses  = 0;
  int   pulses_before;

  if_axi_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_en   (fetch_en),
    .fetch_addr (fetch_addr),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_addr  (inst_addr),
    .ar_valid   (ar_valid),
    .ar_ready   (ar_ready),
    .ar_addr    (ar_addr),
    .ar_len     (ar_len),
    .ar_size    (ar_size),
    .ar_burst   (ar_burst),
    .ar_prot    (ar_prot),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_data     (r_data),
    .r_resp     (r_resp),
    .r_last     (r_last)
`ifdef IF_FETCH_ERR_CHK_EN
    ,
    .fetch_err  (fetch_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (inst_valid === 1'b1) pulses <= pulses + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Full fetch with AR stalled ar_dly cycles and R delayed r_dly cycles; returns at the
  // negedge where inst_valid should be high (state is IDLE there).
  task automatic do_fetch(input logic [63:0] a, input logic [63:0] d, input logic [1:0] resp,
                          input int ar_dly, input int r_dly);
    exp_t        e;
    logic [63:0] exp_ar;
    e.inst = a[2] ? d[63:32] : d[31:0];
    e.addr = a;
    e.err  = (resp != 2'b00);
    sb.push_back(e);
    exp_ar = {a[63:3], 3'b000};

    fetch_addr = a;
    fetch_en   = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    chk("ar_valid_rise", {63'd0, ar_valid}, 64'd1);
    chk("ar_addr", ar_addr, exp_ar);
    chk("ar_consts", {48'd0, ar_len, ar_size, ar_burst, ar_prot},
        {48'd0, 8'd0, 3'b011, 2'b01, 3'b100});
    chk("r_ready_in_addr", {63'd0, r_ready}, 64'd0);
    chk("inst_valid_low_in_addr", {63'd0, inst_valid}, 64'd0);

    for (int i = 0; i < ar_dly; i++) begin
      fetch_addr = {$urandom, $urandom};
      fetch_en   = 1'b1;
      ar_ready   = 1'b0;
      @(negedge clk);
      chk("ar_hold_valid", {63'd0, ar_valid}, 64'd1);
      chk("ar_hold_addr", ar_addr, exp_ar);
    end
    fetch_en = 1'b0;
    ar_ready = 1'b1;
    @(negedge clk);
    ar_ready = 1'b0;
    chk("ar_valid_drop", {63'd0, ar_valid}, 64'd0);
    chk("r_ready_in_data", {63'd0, r_ready}, 64'd1);

    for (int i = 0; i < r_dly; i++) begin
      fetch_addr = {$urandom, $urandom};
      fetch_en   = 1'b1;
      @(negedge clk);
      chk("r_ready_wait", {63'd0, r_ready}, 64'd1);
      chk("inst_valid_wait", {63'd0, inst_valid}, 64'd0);
    end
    fetch_en = 1'b0;
    r_valid  = 1'b1;
    r_data   = d;
    r_resp   = resp;
    @(negedge clk);
    r_valid = 1'b0;
    r_data  = {$urandom, $urandom};
    r_resp  = 2'b00;

    chk("inst_valid_pulse", {63'd0, inst_valid}, 64'd1);
    chk("r_ready_after", {63'd0, r_ready}, 64'd0);
    if (inst_valid === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk("inst", {32'd0, inst}, {32'd0, e.inst});
      chk("inst_addr", inst_addr, e.addr);
`ifdef IF_FETCH_ERR_CHK_EN
      chk("fetch_err", {63'd0, fetch_err}, {63'd0, e.err});
`endif
    end else if (sb.size() > 0) begin
      void'(sb.pop_front());
    end
    $display("[TB] fetch addr=%h data=%h resp=%0d -> inst=%h inst_addr=%h", a, d, resp, inst,
             inst_addr);
  endtask

  task automatic idle_check(input logic [31:0] exp_inst, input logic [63:0] exp_addr);
    @(negedge clk);
    chk("idle_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("idle_ar_valid", {63'd0, ar_valid}, 64'd0);
    chk("hold_inst", {32'd0, inst}, {32'd0, exp_inst});
    chk("hold_inst_addr", inst_addr, exp_addr);
  endtask

  initial begin
    // 1: reset and quiet idle, stray r_valid ignored
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ar_valid", {63'd0, ar_valid}, 64'd0);
    chk("rst_r_ready", {63'd0, r_ready}, 64'd0);
    chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_inst", {32'd0, inst}, 64'd0);
    chk("rst_inst_addr", inst_addr, 64'd0);
`ifdef IF_FETCH_ERR_CHK_EN
    chk("rst_fetch_err", {63'd0, fetch_err}, 64'd0);
`endif
    r_valid = 1'b1;
    r_data  = 64'hDEAD_BEEF_CAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_no_ar", {63'd0, ar_valid}, 64'd0);
      chk("idle_no_r_ready", {63'd0, r_ready}, 64'd0);
      chk("idle_no_inst", {63'd0, inst_valid}, 64'd0);
    end
    r_valid = 1'b0;
    $display("[TB] reset/idle checks done");

    // 2: lower lane, minimum latency
    do_fetch(64'h0000_0000_8000_0000, 64'h0000_0013_0010_0093, 2'b00, 0, 0);
    chk("t2_inst_const", {32'd0, inst}, 64'h0000_0000_0010_0093);
    // 3: back-to-back fetch issued in the inst_valid cycle, upper lane
    do_fetch(64'h0000_0000_8000_0004, 64'h0000_0013_0010_0093, 2'b00, 0, 0);
    chk("t3_inst_const", {32'd0, inst}, 64'h0000_0000_0000_0013);
    idle_check(32'h0000_0013, 64'h0000_0000_8000_0004);

    // 4: stalled AR and R, fetch_addr wiggling during the wait
    pulses_before = pulses;
    do_fetch(64'h0000_0000_8000_0123, 64'h1122_3344_5566_7788, 2'b00, 5, 4);
    idle_check(32'h5566_7788, 64'h0000_0000_8000_0123);
    chk("t4_single_pulse", 64'(pulses - pulses_before), 64'd1);

    // 5: reset while in DATA aborts the read
    pulses_before = pulses;
    fetch_addr = 64'h0000_0000_8000_0010;
    fetch_en   = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    ar_ready = 1'b1;
    @(negedge clk);
    ar_ready = 1'b0;
    chk("t5_in_data", {63'd0, r_ready}, 64'd1);
    rst     = 1'b1;
    r_valid = 1'b1;
    r_data  = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge clk);
    rst     = 1'b0;
    r_valid = 1'b0;
    chk("t5_ar_valid", {63'd0, ar_valid}, 64'd0);
    chk("t5_r_ready", {63'd0, r_ready}, 64'd0);
    chk("t5_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("t5_inst_cleared", {32'd0, inst}, 64'd0);
    @(negedge clk);
    chk("t5_still_idle", {63'd0, ar_valid}, 64'd0);
    chk("t5_no_pulse", 64'(pulses - pulses_before), 64'd0);
    $display("[TB] reset-abort checks done");
    do_fetch(64'h0000_0000_8000_0014, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 1, 2);
    idle_check(32'hAAAA_BBBB, 64'h0000_0000_8000_0014);

`ifdef IF_FETCH_ERR_CHK_EN
    // 6: error response flagged alongside inst, held, then cleared by OKAY
    do_fetch(64'h0000_0000_8000_0020, 64'h0BAD_0BAD_1234_5678, 2'b10, 0, 1);
    idle_check(32'h1234_5678, 64'h0000_0000_8000_0020);
    chk("t6_err_held", {63'd0, fetch_err}, 64'd1);
    do_fetch(64'h0000_0000_8000_0024, 64'h0000_0013_0010_0093, 2'b00, 0, 0);
    chk("t6_err_cleared", {63'd0, fetch_err}, 64'd0);
`endif

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
